pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register; successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one packed payload bus with a valid/ready handshake, an optional 2-entry skid buffer, synchronous flush, and a defined bubble value.
- Stages can be stalled and flushed without combinational ready paths crossing the stage boundary.

Parameters:
- DATA_W, 128, payload width in bits; minimum 1.
- BUBBLE_VAL, {DATA_W{1'b0}}, value driven on out_data whenever out_valid=0. Callers encode safe control values here, e.g. load-type 3'b111 and write-enables 0.
- SKID_EN, 1, 1 = two entries with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, synchronous, active-high
- flush  input  1  synchronous kill of all held entries (branch mispredict/trap)
- in_valid  input  1  upstream has a payload
- in_ready  output  1  stage can accept a payload this cycle
- in_data  input  DATA_W  upstream payload
- out_valid  output  1  out_data holds a real instruction
- out_ready  input  1  downstream accepts this cycle (0 = stall)
- out_data  output  DATA_W  payload to the next stage; BUBBLE_VAL when out_valid=0
- occupancy  output  2  entries held (0..2; max 1 when SKID_EN=0)

Behaviour:
- Transfer rules:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Payload moves only on a fire. in_data is ignored when in_fire=0.
- Storage: main entry (drives out_data) and skid entry (present only when SKID_EN=1).
- States (SKID_EN=1):
  - EMPTY (occupancy 0)
  - ONE (main valid, occupancy 1)
  - FULL (main+skid valid, occupancy 2)
- Transitions:
  - EMPTY: in_fire -> ONE, main<=in_data; else stay.
  - ONE, in_fire & out_fire -> ONE, main<=in_data.
  - ONE, in_fire & !out_fire -> FULL, skid<=in_data.
  - ONE, !in_fire & out_fire -> EMPTY, main<=BUBBLE_VAL.
  - ONE, neither -> hold.
  - FULL: in_ready=0. out_fire -> ONE, main<=skid; else hold.
- in_ready:
  - SKID_EN=1: in_ready = (state != FULL), registered. No combinational path from out_ready.
  - SKID_EN=0: in_ready = !out_valid | out_ready. FULL is unreachable. ONE with in_fire & out_fire reloads main.
- Latency: 1 cycle from in_fire in EMPTY to out_valid=1 with that payload.
- Ordering: strict FIFO. Skid contents are always older than any new input.
- Stall hold: while out_valid=1 and out_ready=0, out_data and out_valid are stable cycle to cycle.
- out_data: registered. Equals main when out_valid=1, BUBBLE_VAL otherwise; never X after reset.
- Flush (priority below rst, above everything else):
  - Next state EMPTY; main<=BUBBLE_VAL; skid invalidated.
  - An in_fire in the same cycle is accepted and discarded.
  - An out_fire in the same cycle completes normally; downstream consumed it.
- Reset:
  - Synchronous; next edge gives out_valid=0, out_data=BUBBLE_VAL, occupancy=0, state EMPTY.
  - in_ready=1 after reset.
  - Reset mid-stall drops all entries.
  - Reset dominates a simultaneous flush, in_fire or out_fire.
- Simultaneous in_fire & out_fire in ONE: throughput 1/cycle, occupancy stays 1.
- No overflow is possible: in_ready=0 in FULL guarantees at most 2 entries. No underflow: out_valid=0 in EMPTY.

Test Plan:
1. Reset, then streaming:
   - Stimulus: rst high 2 cycles, then in_valid=1, in_data=0x1,0x2,0x3 on consecutive cycles, out_ready=1.
   - Required: out_valid=0 and out_data=BUBBLE_VAL during reset; 0x1,0x2,0x3 appear one cycle after each fire; occupancy=1 throughout.
2. Stall into skid:
   - Stimulus: out_ready=0 after 0xA is held, present 0xB.
   - Required: occupancy=2 and in_ready=0 next cycle; out_data holds 0xA.
   - Then out_ready=1: 0xA, then 0xB, in order; in_ready returns to 1 one cycle after the first out_fire.
3. Flush while FULL:
   - Stimulus: flush=1 with entries 0xA/0xB held and in_fire of 0xC in the same cycle.
   - Required: next cycle out_valid=0, out_data=BUBBLE_VAL, occupancy=0; 0xC never appears.
4. Reset dominates flush:
   - Stimulus: rst=1 and flush=1 together with out_ready=0 in FULL.
   - Required: reset values exactly as in scenario 1.
5. SKID_EN=0 configuration:
   - Stimulus: out_ready toggled 1,0,1 under continuous input.
   - Required: in_ready equals !out_valid|out_ready combinationally; occupancy never exceeds 1; no payload lost or duplicated.
6. Drain with non-zero bubble:
   - Stimulus: BUBBLE_VAL=0x7, single input 0x55, then no input.
   - Required: out_data = 0x55 for one cycle, then 0x7 with out_valid=0.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, optional two-entry skid buffer,
// synchronous flush and a bubble value driven whenever the stage holds nothing.
module pipe_stage_skid #(
    parameter int unsigned       DATA_W     = 128,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
    parameter bit                SKID_EN    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // state    | meaning
    // ST_EMPTY | nothing held, out_data = BUBBLE_VAL
    // ST_ONE   | main entry valid
    // ST_FULL  | main and skid valid, skid is the younger entry (SKID_EN=1 only)
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_fire;
    logic              out_fire;

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_valid = (state_q != ST_EMPTY);
    // main is forced to BUBBLE_VAL on every path into EMPTY, so it can drive the output directly
    assign out_data  = main_q;
    assign occupancy = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE_VAL;
            skid_q  <= BUBBLE_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d = ST_ONE;
                    main_d  = in_data;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire && SKID_EN) begin
                    state_d = ST_FULL;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE_VAL;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                    skid_d  = BUBBLE_VAL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                main_d  = BUBBLE_VAL;
                skid_d  = BUBBLE_VAL;
            end
        endcase
        // Anything accepted alongside a flush is dropped; an out_fire has already been consumed.
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE_VAL;
            skid_d  = BUBBLE_VAL;
        end
    end

    if (SKID_EN) begin : g_skid
        logic in_ready_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                in_ready_q <= 1'b1;
            end else begin
                in_ready_q <= (state_d != ST_FULL);
            end
        end

        assign in_ready = in_ready_q;
    end else begin : g_noskid
        assign in_ready = !out_valid || out_ready;
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a skid instance (bubble 0) and a single-entry instance (bubble 0x07),
// each tracked by a queue model that is checked every cycle by its monitor.
module tb_pipe_stage_skid;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic [7:0] a_in_data = 8'h00;
    logic       a_in_ready, a_out_valid;
    logic [7:0] a_out_data;
    logic [1:0] a_occupancy;

    logic       b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic [7:0] b_in_data = 8'h00;
    logic       b_in_ready, b_out_valid;
    logic [7:0] b_out_data;
    logic [1:0] b_occupancy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    bit         a_armed = 1'b0;
    bit         b_armed = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(8), .BUBBLE_VAL(8'h00), .SKID_EN(1'b1)) u_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occupancy)
    );

    pipe_stage_skid #(.DATA_W(8), .BUBBLE_VAL(8'h07), .SKID_EN(1'b0)) u_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occupancy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model for the skid instance: queue head is what must be on out_data.
    always @(negedge clk) begin
        if (a_armed) begin
            chk("a_out_valid", a_out_valid, qa.size() != 0);
            chk("a_out_data", a_out_data, (qa.size() != 0) ? qa[0] : 8'h00);
            chk("a_occupancy", a_occupancy, qa.size());
            chk("a_in_ready", a_in_ready, qa.size() < 2);
        end
        if (rst) begin
            qa.delete();
            a_armed = 1'b1;
        end else begin
            if (a_out_valid && a_out_ready && qa.size() != 0) void'(qa.pop_front());
            if (a_flush) qa.delete();
            else if (a_in_valid && a_in_ready) qa.push_back(a_in_data);
        end
    end

    always @(negedge clk) begin
        if (b_armed) begin
            chk("b_out_valid", b_out_valid, qb.size() != 0);
            chk("b_out_data", b_out_data, (qb.size() != 0) ? qb[0] : 8'h07);
            chk("b_occupancy", b_occupancy, qb.size());
            chk("b_in_ready", b_in_ready, (qb.size() == 0) || b_out_ready);
        end
        if (rst) begin
            qb.delete();
            b_armed = 1'b1;
        end else begin
            if (b_out_valid && b_out_ready && qb.size() != 0) void'(qb.pop_front());
            if (b_flush) qb.delete();
            else if (b_in_valid && b_in_ready) qb.push_back(b_in_data);
        end
    end

    initial begin
        int  idx;
        bit  fired;

        // 1: reset then streaming 1,2,3
        rst = 1'b1;
        tick();
        chk("s1_rst_valid", a_out_valid, 1'b0);
        chk("s1_rst_data", a_out_data, 8'h00);
        chk("s1_rst_bdata", b_out_data, 8'h07);
        tick();
        chk("s1_rst_in_ready", a_in_ready, 1'b1);
        rst = 1'b0;
        a_in_valid = 1'b1; a_out_ready = 1'b1; a_in_data = 8'h01;
        tick();
        chk("s1_data1", a_out_data, 8'h01);
        chk("s1_occ1", a_occupancy, 2'd1);
        a_in_data = 8'h02;
        tick();
        chk("s1_data2", a_out_data, 8'h02);
        a_in_data = 8'h03;
        tick();
        chk("s1_data3", a_out_data, 8'h03);
        chk("s1_occ3", a_occupancy, 2'd1);
        a_in_valid = 1'b0;
        tick();
        chk("s1_drained", a_out_valid, 1'b0);

        // 2: stall into skid
        a_in_valid = 1'b1; a_in_data = 8'h0A; a_out_ready = 1'b0;
        tick();
        chk("s2_holdA", a_out_data, 8'h0A);
        a_in_data = 8'h0B;
        tick();
        chk("s2_occ_full", a_occupancy, 2'd2);
        chk("s2_in_ready_low", a_in_ready, 1'b0);
        chk("s2_stillA", a_out_data, 8'h0A);
        a_in_valid = 1'b0;
        tick();
        chk("s2_stall_stable", a_out_data, 8'h0A);
        a_out_ready = 1'b1;
        tick();
        chk("s2_thenB", a_out_data, 8'h0B);
        chk("s2_in_ready_back", a_in_ready, 1'b1);
        tick();
        chk("s2_empty", a_out_valid, 1'b0);

        // 3: flush while FULL with 0xC presented, then flush in ONE with an accepted 0xE
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 8'h0A;
        tick();
        a_in_data = 8'h0B;
        tick();
        a_flush = 1'b1; a_in_data = 8'h0C;
        tick();
        chk("s3_valid", a_out_valid, 1'b0);
        chk("s3_data", a_out_data, 8'h00);
        chk("s3_occ", a_occupancy, 2'd0);
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        tick();
        chk("s3_no_C", a_out_valid, 1'b0);
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 8'h0D;
        tick();
        a_flush = 1'b1; a_in_data = 8'h0E;
        tick();
        chk("s3_one_flush_valid", a_out_valid, 1'b0);
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        tick();
        chk("s3_no_E", a_out_valid, 1'b0);

        // 4: reset dominates flush while FULL and stalled
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 8'h11;
        tick();
        a_in_data = 8'h22;
        tick();
        chk("s4_full", a_occupancy, 2'd2);
        rst = 1'b1; a_flush = 1'b1;
        tick();
        chk("s4_valid", a_out_valid, 1'b0);
        chk("s4_data", a_out_data, 8'h00);
        chk("s4_occ", a_occupancy, 2'd0);
        chk("s4_in_ready", a_in_ready, 1'b1);
        rst = 1'b0; a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        tick();
        chk("s4_after", a_out_valid, 1'b0);

        // 5: single-entry instance, out_ready pattern 1,0,1 under continuous input
        b_in_valid = 1'b1;
        idx = 0;
        for (int cyc = 0; cyc < 40 && idx < 6; cyc++) begin
            b_in_data   = 8'(8'h31 + idx);
            b_out_ready = ((cyc % 3) != 1);
            @(negedge clk);
            fired = b_in_ready;
            tick();
            if (fired) idx++;
        end
        chk("s5_accepted", idx, 6);
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        tick();
        tick();
        chk("s5_drained", b_out_valid, 1'b0);

        // 6: drain with non-zero bubble
        b_in_valid = 1'b1; b_in_data = 8'h55;
        tick();
        chk("s6_data", b_out_data, 8'h55);
        chk("s6_valid", b_out_valid, 1'b1);
        b_in_valid = 1'b0;
        tick();
        chk("s6_bubble", b_out_data, 8'h07);
        chk("s6_bubble_valid", b_out_valid, 1'b0);
        tick();

        @(negedge clk);
        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
